mem_io_unit: RTL and testbench
==============================

Name: mem_io_unit

Overview:
- Data-side memory and memory-mapped I/O stage directly downstream of the single-cycle 8-bit CPU.
- Consumes the CPU's address (DataA), write data (DataB) and MW, and returns read data to the CPU's Din.
- Contains a small data RAM, four output port registers, three synchronized input ports, a prescaled timer with compare match, and a rising-edge event counter on IN_E[0].

Parameters:
- RAM_DEPTH, 64: data RAM bytes, mapped at 0x00..RAM_DEPTH-1; legal values 1..240.
- PRESCALE, 4: CLK cycles per timer tick; minimum 1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_L  in  1  reset, asynchronous, active-low.
- EN_L  in  1  CPU enable, active-low; writes occur only while EN_L=0.
- ADDR  in  8  byte address, driven from CPU DataA.
- WDATA  in  8  write data, driven from CPU DataB.
- MW  in  1  memory write strobe from the CPU decoder.
- RDATA  out  8  read data to CPU Din; combinational from ADDR.
- IN_E, IN_F, IN_G  in  8 each  asynchronous external input ports.
- OUT_A, OUT_B, OUT_C, OUT_D  out  8 each  registered output ports.
- IRQ  out  1  OR of the STATUS sticky bits.

Behaviour:
- Write enable: we = MW & ~EN_L. All writes commit on the rising CLK edge and are visible on RDATA in the following cycle.
- Read path: RDATA is a pure combinational decode of ADDR, with zero latency, because the CPU is single-cycle. RAM read is asynchronous. The current-cycle write is not bypassed to RDATA.
- Address map:
  - 0x00..RAM_DEPTH-1: RAM, read/write.
  - 0xF0..0xF3: OUT_A..OUT_D, read/write; RDATA returns the register value.
  - 0xF4..0xF6: synchronized IN_E..IN_G, read-only.
  - 0xF8: TIMER count, read-only.
  - 0xF9: CMP, read/write.
  - 0xFA: STATUS, bit0 TMATCH, bit1 EDGE, bits7:2 read 0; write-1-to-clear.
  - 0xFB: EDGECNT, read; any write clears it to 0.
  - All other addresses: read 0x00, writes ignored. Writes to read-only addresses are also ignored.
- Reset (RESET_L=0, asynchronous):
  - OUT_A..OUT_D=0x00, TIMER=0, prescaler=0, CMP=0xFF, STATUS=0, EDGECNT=0, synchronizer and edge-history flops=0.
  - IRQ=0. RDATA follows the decode of the reset state.
  - RAM is not reset; its contents are X until written.
  - Reset asserted mid-operation aborts any write in that cycle.
- Input synchronizers: two flops per input bit. A value on IN_x appears at 0xF4..0xF6 after 2 CLK edges.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps; tick=1 on the cycle it equals PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- Timer:
  - On tick: if TIMER==CMP, then TIMER<=0 and TMATCH<=1; else TIMER<=TIMER+1.
  - Period is (CMP+1)*PRESCALE cycles.
  - CMP=0x00 gives a match on every tick. There is no 8-bit wrap beyond CMP; with CMP=0xFF the sequence is 0xFF->0.
  - A write to CMP loads CMP and clears TIMER and the prescaler to 0 on the same edge, with no match that edge.
- Edge detector:
  - rise = sync_E[0] & ~prev_E0; prev_E0 registers sync_E[0].
  - On rise: EDGE<=1 and EDGECNT<=EDGECNT+1, wrapping 0xFF->0x00.
- Simultaneous events:
  - Hardware set and W1C clear of the same STATUS bit in one cycle: set wins (bit stays 1).
  - EDGECNT write-clear together with rise: result is 0x01.
  - CMP write together with a tick: the CMP write wins (TIMER=0, TMATCH unchanged).
- IRQ = TMATCH | EDGE, combinational from the flops.
- EN_L=1 freezes only writes. Timer, prescaler, synchronizers and the edge counter keep running.

Decomposition:
- Shared package:
  - Address constants ADDR_OUTA..ADDR_OUTD, ADDR_INE..ADDR_ING, ADDR_TIMER, ADDR_CMP, ADDR_STATUS, ADDR_EDGECNT.
  - STATUS bit indices ST_TMATCH=0, ST_EDGE=1.
- Sub-module io_timer: prescaler, TIMER, CMP and TMATCH set logic. Ports: clk, reset, cmp write strobe/data, W1C bit; outputs TIMER, CMP, TMATCH.
- Top level: RAM array, address decode/read mux, port registers, synchronizers, edge detector.

Test Plan:
- Reset values: pulse RESET_L low mid-cycle -> OUT_A..D=0x00 immediately; reads of 0xF9=0xFF, 0xFA=0x00, 0xFB=0x00; IRQ=0.
- RAM/port R/W:
  - Write 0x5A to 0x10 with MW=1, EN_L=0 -> next cycle read 0x10=0x5A.
  - Write 0xC3 to 0xF2 -> OUT_C=0xC3.
  - Same write with EN_L=1 -> no change.
  - Write to 0xF4 -> ignored.
  - Read 0xE0 -> 0x00.
- Timer: PRESCALE=4, write CMP=0x02 -> TMATCH and IRQ rise exactly 12 cycles after the write edge; TIMER sequence 0,1,2,0.
- W1C race: write 0x01 to 0xFA on the same cycle TMATCH sets -> TMATCH stays 1. Clean W1C next period clears it -> IRQ=0.
- Edges: toggle IN_E[0] 0->1 three times -> EDGECNT=0x03 and EDGE=1 after the 2-cycle sync delay. Preload 255 rises -> the next rise wraps EDGECNT to 0x00.
- Sync delay: change IN_G from 0x00 to 0xA5 -> read 0xF6 is 0x00 for 2 edges, then 0xA5.

Source files
------------

// File: rtl/mem_io_unit_pkg.sv
// Shared address map, STATUS bit positions and write-request payload for mem_io_unit.
package mem_io_unit_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] ADDR_OUTA    = 8'hF0;
  localparam logic [DATA_W-1:0] ADDR_OUTB    = 8'hF1;
  localparam logic [DATA_W-1:0] ADDR_OUTC    = 8'hF2;
  localparam logic [DATA_W-1:0] ADDR_OUTD    = 8'hF3;
  localparam logic [DATA_W-1:0] ADDR_INE     = 8'hF4;
  localparam logic [DATA_W-1:0] ADDR_INF     = 8'hF5;
  localparam logic [DATA_W-1:0] ADDR_ING     = 8'hF6;
  localparam logic [DATA_W-1:0] ADDR_TIMER   = 8'hF8;
  localparam logic [DATA_W-1:0] ADDR_CMP     = 8'hF9;
  localparam logic [DATA_W-1:0] ADDR_STATUS  = 8'hFA;
  localparam logic [DATA_W-1:0] ADDR_EDGECNT = 8'hFB;

  localparam int unsigned ST_TMATCH = 0;
  localparam int unsigned ST_EDGE   = 1;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/io_timer.sv
// Prescaled timer with compare register and sticky match flag.
module io_timer
  import mem_io_unit_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_we,
  input  logic [DATA_W-1:0] cmp_wdata,
  input  logic              tmatch_clr,
  output logic [DATA_W-1:0] timer,
  output logic [DATA_W-1:0] cmp,
  output logic              tmatch
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             hit;

  assign tick = (pre == PRE_MAX);
  // A CMP write restarts the period, so it suppresses any match on that edge.
  assign hit  = tick & ~cmp_we & (timer == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      timer  <= '0;
      cmp    <= 8'hFF;
      tmatch <= 1'b0;
    end else begin
      tmatch <= hit | (tmatch & ~tmatch_clr);
      if (cmp_we) begin
        cmp   <= cmp_wdata;
        timer <= '0;
        pre   <= '0;
      end else begin
        pre <= tick ? '0 : pre + PRE_W'(1);
        if (tick) timer <= (timer == cmp) ? '0 : timer + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mem_io_unit.sv
// Data RAM plus memory-mapped I/O (ports, synchronized inputs, timer, edge counter)
// behind a single-cycle CPU; reads are combinational, writes commit on CLK.
module mem_io_unit
  import mem_io_unit_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 64,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              EN_L,
  input  logic [DATA_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              MW,
  output logic [DATA_W-1:0] RDATA,
  input  logic [DATA_W-1:0] IN_E,
  input  logic [DATA_W-1:0] IN_F,
  input  logic [DATA_W-1:0] IN_G,
  output logic [DATA_W-1:0] OUT_A,
  output logic [DATA_W-1:0] OUT_B,
  output logic [DATA_W-1:0] OUT_C,
  output logic [DATA_W-1:0] OUT_D,
  output logic              IRQ
);

  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  wr_req_t           wr;
  logic              we;
  logic              ram_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic [DATA_W-1:0] s1_e, s2_e, s1_f, s2_f, s1_g, s2_g;
  logic              prev_e0;
  logic              rise;
  logic              edge_flag;
  logic [DATA_W-1:0] edge_cnt;

  logic              status_wr;
  logic              cnt_clr;
  logic              cmp_we;
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] cmp;
  logic              tmatch;

  assign wr        = '{addr: ADDR, data: WDATA};
  assign we        = MW & ~EN_L;
  assign ram_sel   = (wr.addr < 8'(RAM_DEPTH));
  assign ram_idx   = wr.addr[RAM_AW-1:0];
  assign status_wr = we & (wr.addr == ADDR_STATUS);
  assign cnt_clr   = we & (wr.addr == ADDR_EDGECNT);
  assign cmp_we    = we & (wr.addr == ADDR_CMP);
  assign rise      = s2_e[0] & ~prev_e0;
  assign IRQ       = tmatch | edge_flag;

  // RAM is never cleared; an asserted reset only blocks the write.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (RESET_L && we && ram_sel) ram[ram_idx] <= wr.data;
  end

  // Output port registers
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      OUT_A <= '0;
      OUT_B <= '0;
      OUT_C <= '0;
      OUT_D <= '0;
    end else if (we) begin
      case (wr.addr)
        ADDR_OUTA: OUT_A <= wr.data;
        ADDR_OUTB: OUT_B <= wr.data;
        ADDR_OUTC: OUT_C <= wr.data;
        ADDR_OUTD: OUT_D <= wr.data;
        default: ;
      endcase
    end
  end

  // Two-flop synchronizers and edge detection on IN_E[0]
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      s1_e      <= '0;
      s2_e      <= '0;
      s1_f      <= '0;
      s2_f      <= '0;
      s1_g      <= '0;
      s2_g      <= '0;
      prev_e0   <= 1'b0;
      edge_flag <= 1'b0;
      edge_cnt  <= '0;
    end else begin
      s1_e      <= IN_E;
      s2_e      <= s1_e;
      s1_f      <= IN_F;
      s2_f      <= s1_f;
      s1_g      <= IN_G;
      s2_g      <= s1_g;
      prev_e0   <= s2_e[0];
      edge_flag <= rise | (edge_flag & ~(status_wr & wr.data[ST_EDGE]));
      if (cnt_clr)   edge_cnt <= {7'd0, rise};
      else if (rise) edge_cnt <= edge_cnt + 8'd1;
    end
  end

  io_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RESET_L),
    .cmp_we    (cmp_we),
    .cmp_wdata (wr.data),
    .tmatch_clr(status_wr & wr.data[ST_TMATCH]),
    .timer     (timer),
    .cmp       (cmp),
    .tmatch    (tmatch)
  );

  // Zero-latency read decode; the write in flight is not forwarded.
  always_comb begin
    RDATA = '0;
    if (ram_sel) begin
      RDATA = ram[ram_idx];
    end else begin
      case (wr.addr)
        ADDR_OUTA:    RDATA = OUT_A;
        ADDR_OUTB:    RDATA = OUT_B;
        ADDR_OUTC:    RDATA = OUT_C;
        ADDR_OUTD:    RDATA = OUT_D;
        ADDR_INE:     RDATA = s2_e;
        ADDR_INF:     RDATA = s2_f;
        ADDR_ING:     RDATA = s2_g;
        ADDR_TIMER:   RDATA = timer;
        ADDR_CMP:     RDATA = cmp;
        ADDR_STATUS: begin
          RDATA[ST_TMATCH] = tmatch;
          RDATA[ST_EDGE]   = edge_flag;
        end
        ADDR_EDGECNT: RDATA = edge_cnt;
        default:      RDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_unit.sv
// Directed and randomized checks of mem_io_unit against a behavioural model.
module tb_mem_io_unit;

  localparam int RAM_DEPTH = 64;
  localparam int PRESCALE  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_l;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       mw;
  logic [7:0] rdata;
  logic [7:0] in_e, in_f, in_g;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic       irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m   [256];
  bit         written [256];
  logic [7:0] out_m   [4];

  mem_io_unit #(
    .RAM_DEPTH(RAM_DEPTH),
    .PRESCALE (PRESCALE)
  ) dut (
    .CLK    (clk),
    .RESET_L(rst_n),
    .EN_L   (en_l),
    .ADDR   (addr),
    .WDATA  (wdata),
    .MW     (mw),
    .RDATA  (rdata),
    .IN_E   (in_e),
    .IN_F   (in_f),
    .IN_G   (in_g),
    .OUT_A  (out_a),
    .OUT_B  (out_b),
    .OUT_C  (out_c),
    .OUT_D  (out_d),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; mw = 1'b1; en_l = 1'b0;
    tick1();
    mw = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    logic [7:0] v;
    logic       prev_bit;
    int         cnt_m;
    int         c;
    int         per;

    rst_n = 1'b0; en_l = 1'b0; addr = 8'hE0; wdata = 8'h00; mw = 1'b0;
    in_e = 8'h00; in_f = 8'h00; in_g = 8'h00;
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    for (int i = 0; i < 4; i++) out_m[i] = 8'h00;
    #22 rst_n = 1'b1;
    tick1();

    // Asynchronous reset in the middle of a cycle
    wr(8'hF0, 8'h11);
    wr(8'hF3, 8'h22);
    chk("outa_pre_reset", out_a, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("outa_reset", out_a, 8'h00);
    chk("outd_reset", out_d, 8'h00);
    rd_chk(8'hF9, 8'hFF, "cmp_reset");
    rd_chk(8'hFA, 8'h00, "status_reset");
    rd_chk(8'hFB, 8'h00, "edgecnt_reset");
    chk("irq_reset", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    tick1();

    // Directed RAM / port accesses
    wr(8'h10, 8'h5A); mem_m[8'h10] = 8'h5A; written[8'h10] = 1'b1;
    rd_chk(8'h10, 8'h5A, "ram_rw");
    tick1();
    wr(8'hF2, 8'hC3); out_m[2] = 8'hC3;
    chk("outc_write", out_c, 8'hC3);
    addr = 8'hF2; wdata = 8'h55; mw = 1'b1; en_l = 1'b1;
    tick1();
    mw = 1'b0; en_l = 1'b0;
    chk("outc_en_l_blocked", out_c, 8'hC3);
    wr(8'hF4, 8'h77);
    rd_chk(8'hF4, 8'h00, "ine_readonly");
    rd_chk(8'hE0, 8'h00, "unmapped_e0");
    tick1();

    // Randomized RAM / port writes with EN_L occasionally high
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      logic       blk;
      a   = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 + $urandom_range(0, 4))
                                        : 8'($urandom_range(0, RAM_DEPTH - 1));
      d   = 8'($urandom);
      blk = ($urandom_range(0, 3) == 0);
      addr = a; wdata = d; mw = 1'b1; en_l = blk;
      tick1();
      mw = 1'b0; en_l = 1'b0;
      if (!blk) begin
        if (a < 8'(RAM_DEPTH)) begin
          mem_m[a] = d; written[a] = 1'b1;
        end else if (a <= 8'hF3) begin
          out_m[a - 8'hF0] = d;
        end
      end
    end
    for (int a = 0; a < RAM_DEPTH; a++) begin
      if (written[a]) begin
        rd_chk(8'(a), mem_m[a], $sformatf("ram_rand[%0d]", a));
        tick1();
      end
    end
    chk("outa_rand", out_a, out_m[0]);
    chk("outb_rand", out_b, out_m[1]);
    chk("outc_rand", out_c, out_m[2]);
    chk("outd_rand", out_d, out_m[3]);
    for (int k = 0; k < 4; k++) begin
      rd_chk(8'(8'hF0 + k), out_m[k], $sformatf("port_read[%0d]", k));
      tick1();
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(RAM_DEPTH, 8'hEF));
      rd_chk(a, 8'h00, $sformatf("unmapped_%02h", a));
      tick1();
    end
    rd_chk(8'hF7, 8'h00, "unmapped_f7");
    rd_chk(8'hFF, 8'h00, "unmapped_ff");
    tick1();

    // Timer with CMP=2: period 12 cycles, count 0,1,2,0
    wr(8'hF9, 8'h02);
    for (int k = 0; k <= 14; k++) begin
      rd_chk(8'hF8, 8'((k / PRESCALE) % 3), $sformatf("timer_k%0d", k));
      chk($sformatf("irq_k%0d", k), {7'd0, irq}, {7'd0, (k >= 3 * PRESCALE)});
      tick1();
    end
    wr(8'hFA, 8'h01);
    chk("irq_after_w1c", {7'd0, irq}, 8'h00);
    repeat (7) tick1();
    wr(8'hFA, 8'h01);
    rd_chk(8'hFA, 8'h01, "w1c_race_set_wins");
    wr(8'hFA, 8'h01);
    chk("irq_clean_w1c", {7'd0, irq}, 8'h00);
    rd_chk(8'hF8, 8'h00, "timer_k25");
    tick1();

    // Randomized compare values, model from elapsed cycles
    for (int r = 0; r < 3; r++) begin
      c   = $urandom_range(0, 5);
      per = (c + 1) * PRESCALE;
      wr(8'hF9, 8'(c));
      wr(8'hFA, 8'h01);
      for (int k = 1; k <= per + 2; k++) begin
        rd_chk(8'hF8, 8'((k / PRESCALE) % (c + 1)), $sformatf("timer_c%0d_k%0d", c, k));
        chk($sformatf("tmatch_c%0d_k%0d", c, k), {7'd0, irq}, {7'd0, (k >= per)});
        tick1();
      end
    end

    // Edge counter: three rising edges on IN_E[0]
    wr(8'hFB, 8'h00);
    for (int i = 0; i < 3; i++) begin
      in_e = 8'h01; repeat (3) tick1();
      in_e = 8'h00; repeat (3) tick1();
    end
    rd_chk(8'hFB, 8'h03, "edgecnt_three");
    rd_chk(8'hFA, {6'd0, 1'b1, rdata[0]}, "edge_flag_set");
    tick1();
    wr(8'hFA, 8'h02);
    addr = 8'hFA; #1;
    chk("edge_flag_cleared", rdata & 8'h02, 8'h00);
    tick1();

    // Clear coinciding with a rise leaves a count of one
    in_e = 8'h01;
    tick1(); tick1();
    wr(8'hFB, 8'h00);
    rd_chk(8'hFB, 8'h01, "edgecnt_clear_and_rise");
    tick1();
    in_e = 8'h00; repeat (4) tick1();

    // Random patterns on IN_E, counting 0->1 transitions of bit 0
    wr(8'hFB, 8'h00);
    cnt_m = 0; prev_bit = 1'b0; v = 8'h00;
    for (int i = 0; i < 50; i++) begin
      v = 8'($urandom);
      if (v[0] && !prev_bit) cnt_m++;
      prev_bit = v[0];
      in_e = v;
      tick1();
    end
    repeat (3) tick1();
    rd_chk(8'hF4, v, "ine_sync_rand");
    rd_chk(8'hFB, 8'(cnt_m), "edgecnt_rand");
    in_e = 8'h00; repeat (4) tick1();

    // 255 rises then one more wraps to zero
    wr(8'hFB, 8'h00);
    for (int i = 0; i < 255; i++) begin
      in_e = 8'h01; tick1();
      in_e = 8'h00; tick1();
    end
    repeat (3) tick1();
    rd_chk(8'hFB, 8'hFF, "edgecnt_255");
    tick1();
    in_e = 8'h01; tick1();
    in_e = 8'h00; repeat (4) tick1();
    rd_chk(8'hFB, 8'h00, "edgecnt_wrap");
    tick1();

    // Two-edge synchronizer latency on IN_G
    in_g = 8'hA5;
    rd_chk(8'hF6, 8'h00, "ing_edge0");
    tick1();
    rd_chk(8'hF6, 8'h00, "ing_edge1");
    tick1();
    rd_chk(8'hF6, 8'hA5, "ing_edge2");
    in_f = 8'h3C;
    repeat (2) tick1();
    rd_chk(8'hF5, 8'h3C, "inf_sync");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
